apds_i2c_target: RTL and testbench
==================================

# apds_i2c_target

I2C target (responder) that answers the command protocol our APDS-9901 driver issues as initiator, at device address 0x39. Used as a sensor stand-in on the FPGA and as the bus model in the driver's testbench. Provides a 32×8 register file with APDS-style command bytes (0x80 single register, 0xA0 auto-increment) and serves ALS/IR/proximity data from input ports. Sits on the shared I2C pins; SCL and SDA are oversampled on the system clock.

## Interface

Parameters:
- DEV_ADDR, 7'h39, 7-bit address this target responds to.
- HOLD_CYC, 4, clk cycles after a detected SCL fall before SDA is changed.

Ports:
- clk, input, 1, system clock (≥ 20× SCL rate).
- rst_n, input, 1, asynchronous active-low reset.
- i2c_scl, input, 1, bus clock; this target never stretches SCL.
- i2c_sda, inout, 1, bus data, open-drain: driven 0 or released to z, never driven 1.
- ch0_dat, input, 16, ALS value served at registers 0x14/0x15.
- ch1_dat, input, 16, IR value served at registers 0x16/0x17.
- prox_dat, input, 16, proximity value served at registers 0x18/0x19.
- enable_reg, output, 8, current content of register 0x00.
- wr_strobe, output, 1, one-clk pulse per register written by the bus.
- wr_addr, output, 5, register address of that write.
- wr_data, output, 8, data of that write.

## Operation

- Inputs pass through 2-FF synchronizers, then a 1-clk-delayed copy for edge detection.
- START/repeated START: SDA falls while SCL high → go to ADDR from any state, clear bit counter.
- STOP: SDA rises while SCL high → IDLE from any state, release SDA.
- Bits are sampled on SCL rising edge, MSB first. SDA is changed only HOLD_CYC clks after SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR: 8 bits received. Bits[7:1] == DEV_ADDR → drive ACK (SDA low) for the 9th clock. Then CMD for a write, RDATA for a read. On mismatch, release SDA and go to IDLE, ignoring the bus until the next START.
- CMD: byte with bit7 = 1 → ACK. Pointer ← bits[4:0]; auto-increment flag ← (bits[6:5] == 2'b01). Bit7 = 0 → NACK, then IDLE.
- WDATA: after 8 bits, write reg[ptr] and pulse wr_strobe/wr_addr/wr_data in that same clk, then ACK. Writes to 0x14–0x19 are ACKed but not stored, and produce no strobe. Pointer advances if auto-increment is set.
- RDATA: load the shift register at the SCL fall ending the ACK phase, then shift out 8 bits.
- RDATA_ACK: release SDA and sample the initiator bit on SCL rise. ACK (0) → advance pointer if auto-increment is set, then RDATA. NACK (1) → IDLE-wait for STOP or START.
- Read mapping: 0x14/0x16/0x18 return the low byte of the corresponding input and snapshot that input's high byte into a holding register. 0x15/0x17/0x19 return the holding register, so a 16-bit pair is coherent. All other addresses return reg[addr].
- Pointer is 5 bits and wraps 0x1F → 0x00.
- After a read address byte, the pointer keeps its value from the last command byte.
- Repeated START keeps the pointer.

## Timing

- Reset values:
  - all registers 0x00, enable_reg 0x00
  - wr_strobe 0, wr_addr 0, wr_data 0
  - SDA released, state IDLE, pointer 0, auto-increment 0
- Input-to-detection latency is 3 clks (2 sync + 1 edge).
- wr_strobe goes high 3 clks after the 8th data-bit SCL rise and lasts exactly 1 clk. enable_reg updates the clk after that.
- ACK/data-bit drive begins HOLD_CYC clks after the SCL fall is detected. ACK is released at the SCL fall ending the 9th clock (plus HOLD_CYC).
- START or STOP during any byte aborts it: no write, no strobe, SDA released the same clk.
- rst_n low mid-transfer releases SDA combinationally-from-register on the next edge of the async reset. No partial write occurs.

## Structure

- Shared package: DEV_ADDR default, state encoding, register address constants (REG_ENABLE 0x00, REG_CDATAL 0x14, REG_IRDATAL 0x16, REG_PDATAL 0x18), command bit masks (CMD 0x80, AUTO_INC 0x20).
- One natural sub-module, i2c_bus_monitor: synchronizers, edge detect, and scl_rise/scl_fall/start/stop pulses. FSM and register file live in the top.

## Test plan

- Write 0x39/W, cmd 0x80, data 0x0F, STOP → three ACKs; wr_strobe once with wr_addr 0x00, wr_data 0x0F; enable_reg = 0x0F.
- Auto-increment write: cmd 0xA1, data 0x11, 0x22, 0x33 → regs 0x01–0x03 = 0x11/0x22/0x33; three strobes.
- Auto-increment read: ch0_dat = 0x1234, cmd 0xB4, repeated START, 0x39/R, then read 2 bytes (ACK, NACK) → bytes 0x34, 0x12. Changing ch0_dat to 0xABCD between the two bytes still returns 0x12.
- Address 0x29 → NACK on the address byte; SDA never driven low for the rest of the transfer.
- cmd 0x1F (bit7 clear) → NACK; no strobe.
- STOP after 4 data bits of a write → no strobe, reg unchanged. rst_n pulsed mid-read → SDA released and enable_reg = 0x00.

Source files
------------

// File: rtl/apds_i2c_target_pkg.sv
// Shared constants and types for the APDS-style I2C target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apds_i2c_target_pkg;

    localparam logic [6:0] DEV_ADDR_DEF = 7'h39;

    // Register map
    localparam logic [4:0] REG_ENABLE  = 5'h00;
    localparam logic [4:0] REG_CDATAL  = 5'h14;
    localparam logic [4:0] REG_IRDATAL = 5'h16;
    localparam logic [4:0] REG_PDATAL  = 5'h18;

    // Command byte fields: bit7 marks a command, bits[6:5] select the transaction type
    localparam logic [7:0] CMD_MASK      = 8'h80;
    localparam logic [7:0] CMD_TYPE_MASK = 8'h60;
    localparam logic [7:0] AUTO_INC      = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CMD,
        ST_CMD_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_t;

    // Sensor data registers are sourced from input ports and cannot be written
    function automatic logic is_data_reg(input logic [4:0] addr);
        return (addr >= REG_CDATAL) && (addr <= (REG_PDATAL + 5'd1));
    endfunction

endpackage

// File: rtl/apds_i2c_target_i2c_bus_monitor.sv
// Oversamples SCL/SDA: 2-FF synchronizers, delayed copy, edge/START/STOP pulses.
// Latency: a pin change shows up as a pulse 3 clk edges later (2 sync + 1 edge).
// Backpressure: none; pulses are single-clk and always produced.
//
// Ports: clk, rst_n; scl/sda raw pins in; scl_rise/scl_fall/start/stop one-clk
// pulses out; sda_lvl is the synchronized SDA level aligned with scl_rise.
module i2c_bus_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_lvl
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Reset to the idle-bus level so coming out of reset never looks like START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_rise = scl_sync[1] & ~scl_d;
    assign scl_fall = ~scl_sync[1] & scl_d;
    // SDA edges only count as START/STOP while SCL is stably high
    assign start    = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
    assign stop     = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
    assign sda_lvl  = sda_sync[1];

endmodule

// File: rtl/apds_i2c_target.sv
// I2C target answering APDS-9901 command protocol; 32x8 regs, sensor data from ports.
// Latency: wr_strobe 3 clks after 8th data-bit SCL rise; SDA changes HOLD_CYC clks after SCL fall.
// Backpressure: none; never stretches SCL, all bus timing is set by the initiator.
//
// Ports: clk, rst_n; i2c_scl in, i2c_sda open-drain inout; ch0/ch1/prox_dat 16-bit
// sensor inputs; enable_reg mirrors reg 0x00; wr_strobe/wr_addr/wr_data report bus writes.
module apds_i2c_target
    import apds_i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
    parameter int         HOLD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [15:0] ch0_dat,
    input  logic [15:0] ch1_dat,
    input  logic [15:0] prox_dat,
    output logic [7:0]  enable_reg,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [7:0]  wr_data
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    logic scl_rise, scl_fall, start, stop, sda_lvl;

    i2c_bus_monitor u_mon (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (i2c_scl),
        .sda      (i2c_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_lvl  (sda_lvl)
    );

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, cnt_nxt;
    logic [7:0]    rx_sh, tx_sh, hold_hi;
    logic [4:0]    ptr;
    logic          auto_inc, rw;
    logic          sda_oe, drv_tgt;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    regs [32];

    logic [7:0] rx_byte, rd_byte;
    logic       rx_shift, tx_shift, tx_load, sched, sched_low, abort;
    logic       cmd_ld, wr_do, ptr_inc, rw_ld, addr_match;

    assign rx_byte    = {rx_sh[6:0], sda_lvl};
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
    assign i2c_sda    = sda_oe ? 1'b0 : 1'bz;

    // Read mux: low byte of a sensor pair is live, high byte comes from the
    // snapshot taken when the low byte was loaded.
    always_comb begin
        rd_byte = regs[ptr];
        case (ptr)
            REG_CDATAL:                      rd_byte = ch0_dat[7:0];
            REG_IRDATAL:                     rd_byte = ch1_dat[7:0];
            REG_PDATAL:                      rd_byte = prox_dat[7:0];
            REG_CDATAL + 5'd1,
            REG_IRDATAL + 5'd1,
            REG_PDATAL + 5'd1:               rd_byte = hold_hi;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // ACK phases use bit_cnt as a two-step marker: 0 = waiting for the fall that
    // ends bit 8, 1 = the 9th SCL rise has been seen.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        tx_load   = 1'b0;
        sched     = 1'b0;
        sched_low = 1'b0;
        abort     = 1'b0;
        cmd_ld    = 1'b0;
        wr_do     = 1'b0;
        ptr_inc   = 1'b0;
        rw_ld     = 1'b0;
        if (start) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = '0;
            abort     = 1'b1;
        end else if (stop) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            abort     = 1'b1;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    rx_shift = 1'b1;
                    cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = addr_match ? ST_ADDR_ACK : ST_IDLE;
                        rw_ld     = addr_match;
                    end
                end
                ST_CMD: if (scl_rise) begin
                    rx_shift = 1'b1;
                    cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if ((rx_byte & CMD_MASK) != 8'h00) begin
                            cmd_ld    = 1'b1;
                            state_nxt = ST_CMD_ACK;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    rx_shift = 1'b1;
                    cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        wr_do     = 1'b1;
                        ptr_inc   = auto_inc;
                        state_nxt = ST_WDATA_ACK;
                    end
                end
                ST_ADDR_ACK, ST_CMD_ACK, ST_WDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_nxt = 3'd1;
                    end else if (scl_fall) begin
                        sched = 1'b1;
                        if (bit_cnt == 3'd0) begin
                            sched_low = 1'b1;
                        end else begin
                            cnt_nxt = '0;
                            if (state == ST_ADDR_ACK && rw) begin
                                tx_load   = 1'b1;
                                sched_low = ~rd_byte[7];
                                state_nxt = ST_RDATA;
                            end else begin
                                state_nxt = (state == ST_ADDR_ACK) ? ST_CMD : ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nxt = ST_RDATA_ACK;
                    end else if (scl_fall) begin
                        tx_shift  = 1'b1;
                        sched     = 1'b1;
                        sched_low = ~tx_sh[6];
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            ptr_inc = auto_inc;
                            cnt_nxt = 3'd1;
                        end
                    end else if (scl_fall) begin
                        sched = 1'b1;
                        if (bit_cnt == 3'd1) begin
                            tx_load   = 1'b1;
                            sched_low = ~rd_byte[7];
                            cnt_nxt   = '0;
                            state_nxt = ST_RDATA;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            hold_hi    <= '0;
            ptr        <= '0;
            auto_inc   <= 1'b0;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            drv_tgt    <= 1'b0;
            hold_cnt   <= '0;
            enable_reg <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_strobe  <= 1'b0;
            enable_reg <= regs[REG_ENABLE];
            if (rx_shift) rx_sh <= rx_byte;
            if (rw_ld) rw <= rx_byte[0];
            if (cmd_ld) begin
                ptr      <= rx_byte[4:0];
                auto_inc <= ((rx_byte & CMD_TYPE_MASK) == AUTO_INC);
            end else if (ptr_inc) begin
                ptr <= ptr + 5'd1;
            end
            if (wr_do && !is_data_reg(ptr)) begin
                regs[ptr] <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
            end
            if (tx_load) begin
                tx_sh <= rd_byte;
                case (ptr)
                    REG_CDATAL:  hold_hi <= ch0_dat[15:8];
                    REG_IRDATAL: hold_hi <= ch1_dat[15:8];
                    REG_PDATAL:  hold_hi <= prox_dat[15:8];
                    default: ;
                endcase
            end else if (tx_shift) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            // SDA changes are deferred HOLD_CYC clks past the SCL fall so the
            // initiator sees stable data hold; START/STOP releases at once.
            if (abort) begin
                sda_oe   <= 1'b0;
                hold_cnt <= '0;
            end else if (sched) begin
                drv_tgt  <= sched_low;
                hold_cnt <= HW'(HOLD_CYC);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) sda_oe <= drv_tgt;
            end
        end
    end

endmodule

// File: tb/tb_apds_i2c_target.sv
module tb_apds_i2c_target;

    localparam int Q = 100;   // quarter SCL period in ns (10 clks)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        tb_low = 1'b0;
    logic [15:0] ch0_dat = 16'h1234;
    logic [15:0] ch1_dat = 16'h5678;
    logic [15:0] prox_dat = 16'h9ABC;
    logic [7:0]  enable_reg;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    wire         i2c_sda;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic mon_en = 1'b0;
    int bad_low = 0;

    pullup (i2c_sda);
    assign i2c_sda = tb_low ? 1'b0 : 1'bz;

    apds_i2c_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i2c_scl    (scl),
        .i2c_sda    (i2c_sda),
        .ch0_dat    (ch0_dat),
        .ch1_dat    (ch1_dat),
        .prox_dat   (prox_dat),
        .enable_reg (enable_reg),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt <= strobe_cnt + 1;
            last_addr  <= wr_addr;
            last_data  <= wr_data;
        end
        if (mon_en && !tb_low && i2c_sda === 1'b0) bad_low <= bad_low + 1;
    end

    // ---------------- bus initiator ----------------
    task automatic bit_xfer(input logic b, output logic r);
        #(Q); tb_low = ~b;
        #(Q); scl = 1'b1;
        #(Q); r = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
        #(Q); scl = 1'b0;
    endtask

    task automatic i2c_start();
        tb_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); tb_low = 1'b1;
        #(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #(Q); tb_low = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); tb_low = 1'b0;
        #(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d = {d[6:0], r};
        end
        bit_xfer(nack, r);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (enable_reg !== 8'h00) begin failures++; $display("FAIL reset_enable got=%h exp=00", enable_reg); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
        checks++; if (wr_addr !== 5'h00 || wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr got=%h/%h exp=00/00", wr_addr, wr_data); end
        checks++; if (i2c_sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", i2c_sda); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h80, a1);
        write_byte(8'h0F, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL sw_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL sw_strobes got=%0d exp=1", strobe_cnt - s0); end
        checks++; if (last_addr !== 5'h00 || last_data !== 8'h0F) begin failures++; $display("FAIL sw_wr got=%h/%h exp=00/0f", last_addr, last_data); end
        checks++; if (enable_reg !== 8'h0F) begin failures++; $display("FAIL sw_enable got=%h exp=0f", enable_reg); end
    endtask

    task automatic test_auto_write();
        logic a;
        logic [7:0] d0, d1, d2;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'hA1, a);
        write_byte(8'h11, a);
        write_byte(8'h22, a);
        write_byte(8'h33, a);
        i2c_stop();
        checks++; if (strobe_cnt - s0 !== 3) begin failures++; $display("FAIL aw_strobes got=%0d exp=3", strobe_cnt - s0); end
        checks++; if (last_addr !== 5'h03 || last_data !== 8'h33) begin failures++; $display("FAIL aw_last got=%h/%h exp=03/33", last_addr, last_data); end
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'hA1, a);
        i2c_start();
        write_byte(8'h73, a);
        read_byte(1'b0, d0);
        read_byte(1'b0, d1);
        read_byte(1'b1, d2);
        i2c_stop();
        checks++; if ({d0, d1, d2} !== 24'h112233) begin failures++; $display("FAIL aw_readback got=%h exp=112233", {d0, d1, d2}); end
    endtask

    task automatic test_auto_read();
        logic a0, a1, a2;
        logic [7:0] lo, hi;
        ch0_dat = 16'h1234;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'hB4, a1);
        i2c_start();
        write_byte(8'h73, a2);
        read_byte(1'b0, lo);
        ch0_dat = 16'hABCD;
        read_byte(1'b1, hi);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL ar_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (lo !== 8'h34) begin failures++; $display("FAIL ar_low got=%h exp=34", lo); end
        checks++; if (hi !== 8'h12) begin failures++; $display("FAIL ar_high_coherent got=%h exp=12", hi); end
    endtask

    task automatic test_wrap_and_readonly();
        logic a, ar;
        logic [7:0] d0, d1;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'hBF, a);
        write_byte(8'h5A, a);
        i2c_stop();
        checks++; if (last_addr !== 5'h1F || last_data !== 8'h5A) begin failures++; $display("FAIL wr_1f got=%h/%h exp=1f/5a", last_addr, last_data); end
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'h94, a);
        write_byte(8'h99, ar);
        i2c_stop();
        checks++; if (ar !== 1'b0) begin failures++; $display("FAIL ro_ack got=%b exp=0", ar); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL ro_strobe got=%0d exp=0", strobe_cnt - s0); end
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'hBF, a);
        i2c_start();
        write_byte(8'h73, a);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        checks++; if ({d0, d1} !== 16'h5A0F) begin failures++; $display("FAIL ptr_wrap got=%h exp=5a0f", {d0, d1}); end
    endtask

    task automatic test_addr_nack();
        logic a0, a1, a2;
        int s0;
        s0 = strobe_cnt;
        bad_low = 0;
        i2c_start();
        write_byte(8'h52, a0);
        mon_en = 1'b1;
        write_byte(8'h80, a1);
        write_byte(8'h55, a2);
        mon_en = 1'b0;
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL an_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (bad_low !== 0) begin failures++; $display("FAIL an_sda_low got=%0d exp=0", bad_low); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL an_strobe got=%0d exp=0", strobe_cnt - s0); end
    endtask

    task automatic test_cmd_nack();
        logic a0, a1, a2;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h1F, a1);
        write_byte(8'h77, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b011) begin failures++; $display("FAIL cn_acks got=%b exp=011", {a0, a1, a2}); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL cn_strobe got=%0d exp=0", strobe_cnt - s0); end
    endtask

    task automatic test_stop_abort();
        logic a, r;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'h80, a);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
        i2c_stop();
        #(4 * Q);
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL sa_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (enable_reg !== 8'h0F) begin failures++; $display("FAIL sa_enable got=%h exp=0f", enable_reg); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'h80, a);
        i2c_start();
        write_byte(8'h73, a);
        #(2 * Q);
        // reg 0x00 = 0x0F, so the first data bit is 0 and the target pulls SDA low
        checks++; if (i2c_sda !== 1'b0) begin failures++; $display("FAIL mr_drive got=%b exp=0", i2c_sda); end
        rst_n = 1'b0;
        #20;
        checks++; if (i2c_sda !== 1'b1) begin failures++; $display("FAIL mr_release got=%b exp=1", i2c_sda); end
        checks++; if (enable_reg !== 8'h00) begin failures++; $display("FAIL mr_enable got=%h exp=00", enable_reg); end
        rst_n = 1'b1;
        #(Q); scl = 1'b1;
        #(Q);
    endtask

    initial begin
        #21;
        test_reset();
        rst_n = 1'b1;
        #(2 * Q);
        test_single_write();
        test_auto_write();
        test_auto_read();
        test_wrap_and_readonly();
        test_addr_nack();
        test_cmd_nack();
        test_stop_abort();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
